col_block_feeder: RTL

Upstream stage of col_dct. Takes an unsigned 8-bit pixel stream in row-major order, 64 pixels per 8x8 block. Captures each block into a ping-pong pair of 8x8 banks, level-shifts the pixels to signed, and emits one full column (8 samples) per cycle. Output is valid-only and drives col_dct's i_valid/i_data0..7 directly; col_dct has no backpressure.

---
 rtl/col_block_feeder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/col_block_feeder.sv
// col_block_feeder
// Collects an unsigned 8-bit pixel stream (row-major, 64 pixels per 8x8
// block) into two ping-pong banks. Each full bank is read out one column
// per cycle as eight level-shifted signed samples for the column DCT.
//
// Ports:
//   i_clk          clock, everything on the rising edge
//   i_rst          synchronous active-high reset
//   i_valid        pixel strobe, a pixel is taken when i_valid && o_ready
//   i_pixel        unsigned pixel; index n -> row n[5:3], column n[2:0]
//   o_ready        current write bank is free
//   o_valid        one column is present on o_data0..o_data7
//   o_data0..7     signed samples of rows 0..7 of the current column
//   o_col_idx      column index of the current output
//   o_blk_start    high together with column 0 of each block
module col_block_feeder #(
  parameter int LEVEL_OFFSET = 128
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_pixel,
  output logic       o_ready,
  output logic       o_valid,
  output logic [7:0] o_data0,
  output logic [7:0] o_data1,
  output logic [7:0] o_data2,
  output logic [7:0] o_data3,
  output logic [7:0] o_data4,
  output logic [7:0] o_data5,
  output logic [7:0] o_data6,
  output logic [7:0] o_data7,
  output logic [2:0] o_col_idx,
  output logic       o_blk_start
);

  typedef enum logic {IDLE, READ} state_t;

  state_t     state_q, state_d;
  logic [5:0] wr_cnt_q, wr_cnt_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [2:0] rd_col_q, rd_col_d;
  logic [1:0] full_q, full_d;
  logic       valid_q, valid_d;
  logic       blk_start_q, blk_start_d;
  logic [2:0] col_idx_q, col_idx_d;

  logic       wr_en;
  logic       rd_en;
  logic [7:0] row_out [8];

  assign o_ready = !full_q[wr_bank_q];
  assign wr_en   = i_valid && o_ready;
  assign rd_en   = (state_q == READ);

  // Write side: fill the current bank, flip banks after the 64th pixel.
  // The read side frees its bank after column 7; the two banks differ so
  // both updates can land on the same edge.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    full_d    = full_q;
    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + 6'd1;
      if (wr_cnt_q == 6'd63) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end
    if (rd_en && rd_col_q == 3'd7) begin
      full_d[rd_bank_q] = 1'b0;
    end
  end

  // Read FSM: one IDLE cycle decides, READ emits eight columns back to back.
  always_comb begin
    state_d     = state_q;
    rd_col_d    = rd_col_q;
    rd_bank_d   = rd_bank_q;
    valid_d     = 1'b0;
    blk_start_d = 1'b0;
    col_idx_d   = col_idx_q;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d  = READ;
          rd_col_d = 3'd0;
        end
      end
      READ: begin
        valid_d     = 1'b1;
        blk_start_d = (rd_col_q == 3'd0);
        col_idx_d   = rd_col_q;
        rd_col_d    = rd_col_q + 3'd1;
        if (rd_col_q == 3'd7) begin
          rd_bank_d = !rd_bank_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      wr_cnt_q    <= 6'd0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_col_q    <= 3'd0;
      full_q      <= 2'b00;
      valid_q     <= 1'b0;
      blk_start_q <= 1'b0;
      col_idx_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      rd_col_q    <= rd_col_d;
      full_q      <= full_d;
      valid_q     <= valid_d;
      blk_start_q <= blk_start_d;
      col_idx_q   <= col_idx_d;
    end
  end

  // One small memory per row so a whole column is readable in one cycle.
  // Address is {bank, column}; the output register doubles as read register.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_row
      logic [7:0] row_mem [0:15];
      logic [7:0] shifted;
      logic [7:0] data_q, data_d;

      always_ff @(posedge i_clk) begin
        if (wr_en && wr_cnt_q[5:3] == 3'(gi)) begin
          row_mem[{wr_bank_q, wr_cnt_q[2:0]}] <= i_pixel;
        end
      end

      // Modulo-256 subtraction equals the 9-bit signed result truncated.
      assign shifted = row_mem[{rd_bank_q, rd_col_q}] - 8'(LEVEL_OFFSET);

      always_comb begin
        data_d = data_q;
        if (rd_en) begin
          data_d = shifted;
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          data_q <= 8'd0;
        end else begin
          data_q <= data_d;
        end
      end

      assign row_out[gi] = data_q;
    end
  endgenerate

  assign o_valid     = valid_q;
  assign o_blk_start = blk_start_q;
  assign o_col_idx   = col_idx_q;
  assign o_data0     = row_out[0];
  assign o_data1     = row_out[1];
  assign o_data2     = row_out[2];
  assign o_data3     = row_out[3];
  assign o_data4     = row_out[4];
  assign o_data5     = row_out[5];
  assign o_data6     = row_out[6];
  assign o_data7     = row_out[7];

endmodule
